// File: rtl/async_cpu_pkg.sv
// Shared types for the write-back path: register-file geometry, buffered
// result entry and the write-port FSM states.
package async_cpu_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 16;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      WAIT  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry circular buffer of pending register writes. Exposes the head for
// the write port and every slot's valid/address for the hazard compare.
module wb_fifo
   import async_cpu_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [REG_ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_pop,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [1:0]            o_count,
   output logic [REG_ADDR_W-1:0] o_head_addr,
   output logic [DATA_W-1:0]     o_head_data,
   output logic [1:0]            o_valid,
   output logic [REG_ADDR_W-1:0] o_addr0,
   output logic [REG_ADDR_W-1:0] o_addr1
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   wb_entry_t  r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;

   logic       w_push_ok;
   logic       w_pop_ok;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == 2'd0);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Slot contents need no reset: nothing reads a slot unless it is valid.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= '{addr: i_addr, data: i_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count     = r_count;
   assign o_head_addr = r_mem[r_rd_ptr].addr;
   assign o_head_data = r_mem[r_rd_ptr].data;

   // With one entry held, only the slot under the read pointer is live.
   assign o_valid[0] = (r_count == 2'd2) || ((r_count == 2'd1) && !r_rd_ptr);
   assign o_valid[1] = (r_count == 2'd2) || ((r_count == 2'd1) &&  r_rd_ptr);
   assign o_addr0    = r_mem[0].addr;
   assign o_addr1    = r_mem[1].addr;

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: four-phase capture of execute results into a 2-entry
// buffer, acknowledged register-file writes with timeout, and RAW hazard flags.
module writeback_stage
   import async_cpu_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 8
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  res_req,
   input  logic [REG_ADDR_W-1:0] res_addr,
   input  logic [DATA_W-1:0]     res_data,
   output logic                  res_ack,
   output logic                  write_en,
   output logic [REG_ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0]     write_data,
   input  logic                  reg_ack,
   input  logic [REG_ADDR_W-1:0] haz_addr_a,
   input  logic [REG_ADDR_W-1:0] haz_addr_b,
   output logic                  hit_a,
   output logic                  hit_b,
   output logic [1:0]            pending_cnt,
   output logic                  wb_err
);

   localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   wb_state_t             r_state;
   logic                  r_res_ack;
   logic                  r_write_en;
   logic [REG_ADDR_W-1:0] r_write_addr;
   logic [DATA_W-1:0]     r_write_data;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_wb_err;

   wb_state_t             w_state_nxt;
   logic                  w_we_nxt;
   logic [REG_ADDR_W-1:0] w_waddr_nxt;
   logic [DATA_W-1:0]     w_wdata_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_err_nxt;
   logic                  w_pop;
   logic                  w_push;

   logic                  w_full;
   logic                  w_empty;
   logic [1:0]            w_count;
   logic [REG_ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0]     w_head_data;
   logic [1:0]            w_valid;
   logic [REG_ADDR_W-1:0] w_addr0;
   logic [REG_ADDR_W-1:0] w_addr1;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_addr      (res_addr),
      .i_data      (res_data),
      .i_pop       (w_pop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_valid     (w_valid),
      .o_addr0     (w_addr0),
      .o_addr1     (w_addr1)
   );

   // Capture only while ack is low, so one req phase yields exactly one entry.
   assign w_push = res_req && !r_res_ack && !w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_ack <= 1'b0;
      end else if (w_push) begin
         r_res_ack <= 1'b1;
      end else if (r_res_ack && !res_req) begin
         r_res_ack <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_write_en   <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
         r_cnt        <= '0;
         r_wb_err     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_write_en   <= w_we_nxt;
         r_write_addr <= w_waddr_nxt;
         r_write_data <= w_wdata_nxt;
         r_cnt        <= w_cnt_nxt;
         r_wb_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_we_nxt    = 1'b0;
      w_waddr_nxt = r_write_addr;
      w_wdata_nxt = r_write_data;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_wb_err;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_we_nxt    = 1'b1;
               w_waddr_nxt = w_head_addr;
               w_wdata_nxt = w_head_data;
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (reg_ack) begin
               w_pop       = 1'b1;
               w_state_nxt = IDLE;
            end else if (r_cnt == CNT_MAX) begin
               // No ack in time: flag it and drop the head so later writes still drain.
               w_err_nxt   = 1'b1;
               w_pop       = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // The head keeps flagging its register until it is popped.
   assign hit_a = (w_valid[0] && (w_addr0 == haz_addr_a)) ||
                  (w_valid[1] && (w_addr1 == haz_addr_a));
   assign hit_b = (w_valid[0] && (w_addr0 == haz_addr_b)) ||
                  (w_valid[1] && (w_addr1 == haz_addr_b));

   assign res_ack     = r_res_ack;
   assign write_en    = r_write_en;
   assign write_addr  = r_write_addr;
   assign write_data  = r_write_data;
   assign pending_cnt = w_count;
   assign wb_err      = r_wb_err;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: four-phase driver, register-file model with
// configurable ack delay, and an in-order write scoreboard.
module tb_writeback_stage;

   localparam int TIMEOUT  = 8;
   localparam int BUDGET   = 200;
   localparam int ACK_NEVER = -1;
   localparam int ACK_RAND  = 100;

   logic        clk;
   logic        rst;
   logic        res_req;
   logic [3:0]  res_addr;
   logic [15:0] res_data;
   logic        res_ack;
   logic        write_en;
   logic [3:0]  write_addr;
   logic [15:0] write_data;
   logic        reg_ack;
   logic [3:0]  haz_addr_a;
   logic [3:0]  haz_addr_b;
   logic        hit_a;
   logic        hit_b;
   logic [1:0]  pending_cnt;
   logic        wb_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [19:0] exp_q[$];
   logic [19:0] exp_word;

   // Register-file model state
   int          ack_mode = 0;
   int          rf_dly;
   logic [3:0]  rf_a;
   logic [15:0] rf_d;
   logic [15:0] rf     [16];
   logic [15:0] ref_rf [16];
   logic [15:0] touched;

   writeback_stage #(
      .DEPTH   (2),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .res_req     (res_req),
      .res_addr    (res_addr),
      .res_data    (res_data),
      .res_ack     (res_ack),
      .write_en    (write_en),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .reg_ack     (reg_ack),
      .haz_addr_a  (haz_addr_a),
      .haz_addr_b  (haz_addr_b),
      .hit_a       (hit_a),
      .hit_b       (hit_b),
      .pending_cnt (pending_cnt),
      .wb_err      (wb_err)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Register file: acks one cycle after write_en plus an optional extra delay.
   always begin
      @(negedge clk);
      if (!rst && write_en && (ack_mode != ACK_NEVER)) begin
         rf_a   = write_addr;
         rf_d   = write_data;
         rf_dly = (ack_mode == ACK_RAND) ? int'($urandom_range(0, 3)) : ack_mode;
         @(posedge clk);
         repeat (rf_dly) @(posedge clk);
         #1 reg_ack = 1'b1;
         @(posedge clk);
         #1 reg_ack = 1'b0;
         rf[rf_a] = rf_d;
      end
   end

   // Scoreboard monitor: every write strobe must match the oldest issued result.
   always @(negedge clk) begin
      if (!rst && write_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                     write_addr, write_data);
         end else begin
            exp_word = exp_q.pop_front();
            chk("wr_addr", 32'(write_addr), 32'(exp_word[19:16]));
            chk("wr_data", 32'(write_data), 32'(exp_word[15:0]));
         end
      end
   end

   // Driver: full four-phase transaction, called at a negedge.
   task automatic send(input logic [3:0] a, input logic [15:0] d);
      int n;
      exp_q.push_back({a, d});
      res_addr = a;
      res_data = d;
      res_req  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!res_ack && n < BUDGET);
      chk("send_ack_rise", 32'(res_ack), 32'd1);
      res_req = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (res_ack && n < BUDGET);
      chk("send_ack_fall", 32'(res_ack), 32'd0);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((pending_cnt != 2'd0 || write_en) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(pending_cnt), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      res_req    = 1'b0;
      res_addr   = '0;
      res_data   = '0;
      reg_ack    = 1'b0;
      haz_addr_a = '0;
      haz_addr_b = '0;
      for (int i = 0; i < 16; i++) rf[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_res_ack", 32'(res_ack), 0);
      chk("rst_write_en", 32'(write_en), 0);
      chk("rst_write_addr", 32'(write_addr), 0);
      chk("rst_write_data", 32'(write_data), 0);
      chk("rst_pending", 32'(pending_cnt), 0);
      chk("rst_wb_err", 32'(wb_err), 0);
      chk("rst_hit_a", 32'(hit_a), 0);
      chk("rst_hit_b", 32'(hit_b), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single write: capture at E, strobe after E+1, ack after E+2, pop at E+3
      ack_mode = 0;
      exp_q.push_back({4'd3, 16'h1234});
      res_addr = 4'd3;
      res_data = 16'h1234;
      res_req  = 1'b1;
      @(negedge clk);
      chk("sw_ack_e", 32'(res_ack), 1);
      chk("sw_pending_e", 32'(pending_cnt), 1);
      chk("sw_wen_e", 32'(write_en), 0);
      @(negedge clk);
      chk("sw_wen_e1", 32'(write_en), 1);
      res_req = 1'b0;
      @(negedge clk);
      chk("sw_wen_e2", 32'(write_en), 0);
      chk("sw_reg_ack_e2", 32'(reg_ack), 1);
      chk("sw_pending_e2", 32'(pending_cnt), 1);
      @(negedge clk);
      chk("sw_pending_e3", 32'(pending_cnt), 0);
      chk("sw_res_ack_e3", 32'(res_ack), 0);
      chk("sw_reg3", 32'(rf[3]), 32'h1234);

      // Back-pressure: third request stalls while the buffer is full
      ack_mode = 4;
      send(4'd1, 16'h0111);
      send(4'd2, 16'h0222);
      exp_q.push_back({4'd3, 16'h0333});
      res_addr = 4'd3;
      res_data = 16'h0333;
      res_req  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_stall_ack", 32'(res_ack), 0);
         chk("bp_stall_pending", 32'(pending_cnt), 2);
      end
      begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (!res_ack && n < BUDGET);
         chk("bp_third_ack", 32'(res_ack), 1);
         res_req = 1'b0;
         n = 0;
         do begin @(negedge clk); n++; end while (res_ack && n < BUDGET);
      end
      drain("bp_drain");
      chk("bp_reg1", 32'(rf[1]), 32'h0111);
      chk("bp_reg2", 32'(rf[2]), 32'h0222);
      chk("bp_reg3", 32'(rf[3]), 32'h0333);

      // Hazards: entries 5 and 9 pending
      haz_addr_a = 4'd5;
      haz_addr_b = 4'd7;
      send(4'd5, 16'h5555);
      send(4'd9, 16'h9999);
      chk("hz_pending", 32'(pending_cnt), 2);
      chk("hz_hit_a", 32'(hit_a), 1);
      chk("hz_hit_b_miss", 32'(hit_b), 0);
      haz_addr_b = 4'd9;
      #1;
      chk("hz_hit_b_9", 32'(hit_b), 1);
      begin
         int n;
         n = 0;
         while (pending_cnt != 2'd1 && n < BUDGET) begin @(negedge clk); n++; end
      end
      chk("hz_after_pop_a", 32'(hit_a), 0);
      chk("hz_after_pop_b", 32'(hit_b), 1);
      drain("hz_drain");
      chk("hz_final_a", 32'(hit_a), 0);
      chk("hz_final_b", 32'(hit_b), 0);

      // Timeout: no ack ever; error lands TIMEOUT cycles after entering WAIT
      ack_mode = ACK_NEVER;
      fork
         begin
            send(4'd7, 16'hDEAD);
            send(4'd8, 16'hBEEF);
         end
         begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!write_en && n < BUDGET);
            chk("to_first_write", 32'(write_en), 1);
            for (int k = 1; k <= TIMEOUT + 1; k++) begin
               @(negedge clk);
               if (k == TIMEOUT) begin
                  chk("to_err_early", 32'(wb_err), 0);
                  chk("to_pending_early", 32'(pending_cnt), 2);
               end
               if (k == TIMEOUT + 1) begin
                  chk("to_err_set", 32'(wb_err), 1);
                  chk("to_dropped", 32'(pending_cnt), 1);
               end
            end
         end
      join
      drain("to_drain");
      chk("to_next_written", 32'(exp_q.size()), 0);
      ack_mode = 0;
      send(4'd4, 16'h4444);
      drain("to_recover_drain");
      chk("to_err_sticky", 32'(wb_err), 1);
      chk("to_recover_reg4", 32'(rf[4]), 32'h4444);

      // Mid-operation reset in WAIT with two entries pending
      ack_mode   = 6;
      haz_addr_a = 4'd10;
      send(4'd10, 16'hAAAA);
      send(4'd11, 16'hBBBB);
      chk("mr_pending_before", 32'(pending_cnt), 2);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_pending", 32'(pending_cnt), 0);
      chk("mr_write_en", 32'(write_en), 0);
      chk("mr_res_ack", 32'(res_ack), 0);
      chk("mr_wb_err", 32'(wb_err), 0);
      chk("mr_hit_a", 32'(hit_a), 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (12) @(negedge clk);

      // Randomized traffic against an ordered reference register file
      ack_mode = ACK_RAND;
      touched  = '0;
      for (int t = 0; t < 40; t++) begin
         logic [3:0]  a;
         logic [15:0] d;
         a = 4'($urandom_range(0, 15));
         d = 16'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(a, d);
         ref_rf[a]  = d;
         touched[a] = 1'b1;
      end
      drain("rnd_drain");
      chk("rnd_exp_empty", 32'(exp_q.size()), 0);
      chk("rnd_no_err", 32'(wb_err), 0);
      for (int i = 0; i < 16; i++) begin
         if (touched[i]) chk("rnd_reg", 32'(rf[i]), 32'(ref_rf[i]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
